pc_fetch: RTL

PC_FETCH -- requirements
Module: pc_fetch

---
 rtl/pc_fetch.sv | 102 ++++++++++
 1 files changed

// File: rtl/pc_fetch.sv
// Instruction fetch unit: walks the PC, issues one instruction-memory request at a time
// and hands each returned word to decode, honouring redirects in every state.
module pc_fetch #(
    parameter int                   CPU_WIDTH = 32,
    parameter logic [CPU_WIDTH-1:0] RESET_PC  = 32'h8000_0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 redir_valid,
    input  logic [CPU_WIDTH-1:0] redir_pc,
    output logic                 imem_req_valid,
    input  logic                 imem_req_ready,
    output logic [CPU_WIDTH-1:0] imem_req_addr,
    input  logic                 imem_rsp_valid,
    input  logic [31:0]          imem_rsp_data,
    output logic                 inst_valid,
    input  logic                 inst_ready,
    output logic [31:0]          inst,
    output logic [CPU_WIDTH-1:0] inst_pc,
    output logic [CPU_WIDTH-1:0] curr_pc
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        OUT
    } state_t;

    state_t                 state;
    state_t                 after_inst;
    logic                   drop;
    logic [CPU_WIDTH-1:0]   redir_aligned;
    logic [CPU_WIDTH-1:0]   pc_plus4;

    assign redir_aligned  = redir_pc & ~CPU_WIDTH'(3);
    assign pc_plus4       = curr_pc + CPU_WIDTH'(4);
    assign after_inst     = ena ? REQ : IDLE;

    // Request is a pure decode of the state register, so it drops with the async reset.
    assign imem_req_valid = (state == REQ);
    assign imem_req_addr  = curr_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            curr_pc    <= RESET_PC;
            inst_valid <= 1'b0;
            inst       <= '0;
            inst_pc    <= '0;
            drop       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (redir_valid) curr_pc <= redir_aligned;
                    if (ena) state <= REQ;
                end
                REQ: begin
                    if (redir_valid) curr_pc <= redir_aligned;
                    if (imem_req_ready) begin
                        // A redirect racing the handshake leaves a stale response in flight.
                        drop  <= redir_valid;
                        state <= WAIT;
                    end else if (!ena) begin
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    if (redir_valid) curr_pc <= redir_aligned;
                    if (imem_rsp_valid) begin
                        drop <= 1'b0;
                        if (redir_valid || drop) begin
                            state <= after_inst;
                        end else begin
                            inst       <= imem_rsp_data;
                            inst_pc    <= curr_pc;
                            inst_valid <= 1'b1;
                            state      <= OUT;
                        end
                    end else if (redir_valid) begin
                        drop <= 1'b1;
                    end
                end
                OUT: begin
                    // Redirect beats a same-cycle consume: the held word is discarded, no +4.
                    if (redir_valid) begin
                        curr_pc    <= redir_aligned;
                        inst_valid <= 1'b0;
                        state      <= after_inst;
                    end else if (inst_ready) begin
                        curr_pc    <= pc_plus4;
                        inst_valid <= 1'b0;
                        state      <= after_inst;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
